// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM states, slave word
// addresses, default expected words and the timeout counter sizing rule.
package sysid_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdId,
    StRdTs,
    StDone
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'hACD51302;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h53104B65;

  function automatic int unsigned ctr_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Per-read wait-state counter; expired is asserted on the stalled edge at which
// the count would reach TIMEOUT_CYCLES.
module sysid_timeout_ctr
  import sysid_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = ctr_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  // Combinational so the owning FSM can abort on the very edge the limit is hit.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID, then timestamp), compares
// both words against expected values and publishes captured words and flags.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic        busy,
  output logic        done
);

  state_e state_q, state_d;
  logic   expired;
  logic   ctr_clear;
  logic   ctr_enable;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (AUTO_START || start) state_d = StRdId;
      StRdId: begin
        if (!avm_waitrequest) state_d = StRdTs;
        else if (expired)     state_d = StDone;
      end
      StRdTs: begin
        if (!avm_waitrequest || expired) state_d = StDone;
      end
      StDone: if (start) state_d = StRdId;
      default: state_d = StIdle;
    endcase
  end

  // Each read state is entered through a state change, so the counter restarts per read.
  assign ctr_clear  = (state_d != state_q);
  assign ctr_enable = avm_read && avm_waitrequest;

  sysid_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clock  (clock),
    .reset  (reset),
    .clear  (ctr_clear),
    .enable (ctr_enable),
    .expired(expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      avm_read    <= (state_d == StRdId) || (state_d == StRdTs);
      busy        <= (state_d == StRdId) || (state_d == StRdTs);
      done        <= (state_d == StDone);
      avm_address <= (state_d == StRdTs) ? ADDR_TS : ADDR_ID;
      unique case (state_q)
        StRdId: begin
          if (!avm_waitrequest) begin
            id_value <= avm_readdata;
          end else if (expired) begin
            timeout  <= 1'b1;
            id_match <= 1'b0;
            ts_match <= 1'b0;
          end
        end
        StRdTs: begin
          if (!avm_waitrequest) begin
            ts_value <= avm_readdata;
            id_match <= (id_value == EXPECTED_ID);
            ts_match <= (avm_readdata == EXPECTED_TS);
          end else if (expired) begin
            timeout  <= 1'b1;
            id_match <= 1'b0;
            ts_match <= 1'b0;
          end
        end
        StDone: begin
          if (start) begin
            timeout  <= 1'b0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Randomised and directed bench for sysid_checker against a stall-count model
// and a simple behavioural Avalon slave.
module tb_sysid_checker;

  localparam int unsigned TO = 4;
  localparam logic [31:0] GOOD_ID = 32'hACD51302;
  localparam logic [31:0] GOOD_TS = 32'h53104B65;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic [31:0] id_value, ts_value;
  logic        id_match, ts_match, timeout, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave configuration: stall cycles and data per word.
  int          w_id = 0, w_ts = 0;
  logic [31:0] d_id = '0, d_ts = '0;
  logic [1:0]  key_prev = '0;
  int          stall_n = 0;

  // Model of previously captured words (what the DUT should hold).
  logic [31:0] prev_id = '0, prev_ts = '0;

  sysid_checker #(
    .TIMEOUT_CYCLES(TO),
    .AUTO_START    (1'b1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .id_value       (id_value),
    .ts_value       (ts_value),
    .id_match       (id_match),
    .ts_match       (ts_match),
    .timeout        (timeout),
    .busy           (busy),
    .done           (done)
  );

  always #5 clock = ~clock;

  // Slave: each new read (read rising or address change) stalls for its configured count.
  always @(negedge clock) begin
    if (!avm_read || {avm_read, avm_address} != key_prev) stall_n = 0;
    else if (avm_waitrequest) stall_n = stall_n + 1;
    key_prev        = {avm_read, avm_address};
    avm_waitrequest = avm_read && (stall_n < (avm_address ? w_ts : w_id));
    avm_readdata    = avm_address ? d_ts : d_id;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {54'd0, avm_read, avm_address, id_match, ts_match, timeout, busy, done}, 64'd0);
    check({tag, "_words"}, {id_value, ts_value}, 64'd0);
  endtask

  task automatic run_seq(input int wi, input int wt, input logic [31:0] di,
                         input logic [31:0] dt, input bit use_start, input int glitch_at);
    int          e_edge, n;
    bit          e_to;
    logic [31:0] e_id, e_ts;
    bit          e_im, e_tm;
    logic        a0, r0, wr0;
    // Reference outcome from stall counts alone.
    e_id = prev_id; e_ts = prev_ts; e_im = 0; e_tm = 0; e_to = 0;
    if (wi >= int'(TO)) begin
      e_edge = TO; e_to = 1;
    end else begin
      e_id = di;
      if (wt >= int'(TO)) begin
        e_edge = wi + 1 + TO; e_to = 1;
      end else begin
        e_edge = wi + wt + 2; e_ts = dt;
        e_im = (di == GOOD_ID); e_tm = (dt == GOOD_TS);
      end
    end
    w_id = wi; w_ts = wt; d_id = di; d_ts = dt;
    @(negedge clock);
    if (use_start) start = 1'b1;
    else reset = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("entry_state", {59'd0, done, timeout, id_match, ts_match, busy}, 64'd1);
    check("entry_rd", {62'd0, avm_read, avm_address}, 64'd2);
    n = 0;
    while (!done && n < 50) begin
      a0 = avm_address; r0 = avm_read;
      @(posedge clock);
      wr0 = avm_waitrequest;
      #1;
      n++;
      start = (n == glitch_at);
      if (r0 && wr0 && busy) check("addr_stable", 64'(avm_address), 64'(a0));
    end
    start = 1'b0;
    check("done_edge", 64'(n), 64'(e_edge));
    check("busy_done", {62'd0, busy, done}, 64'd1);
    check("flags", {61'd0, timeout, id_match, ts_match}, {61'd0, e_to, e_im, e_tm});
    check("id_value", 64'(id_value), 64'(e_id));
    check("ts_value", 64'(ts_value), 64'(e_ts));
    if (glitch_at >= 0) begin
      repeat (3) @(posedge clock);
      #1;
      check("start_not_queued", {62'd0, busy, done}, 64'd1);
    end
    prev_id = e_id; prev_ts = e_ts;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");

    run_seq(0, 0, GOOD_ID, GOOD_TS, 1'b0, -1);
    run_seq(0, 0, 32'hDEADBEEF, GOOD_TS, 1'b1, -1);
    run_seq(3, 3, GOOD_ID, GOOD_TS, 1'b1, -1);
    run_seq(1000, 1000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, -1);
    run_seq(0, 3, GOOD_ID, GOOD_TS, 1'b1, 2);

    // Reset while in the timestamp read.
    w_id = 0; w_ts = 3; d_id = GOOD_ID; d_ts = GOOD_TS;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    check("pre_reset_rd_ts", {62'd0, avm_read, avm_address}, 64'd3);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    prev_id = '0; prev_ts = '0;
    run_seq(0, 0, GOOD_ID, GOOD_TS, 1'b0, -1);

    for (int i = 0; i < 12; i++) begin
      run_seq(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              $urandom_range(0, 1) ? GOOD_ID : $urandom(),
              $urandom_range(0, 1) ? GOOD_TS : $urandom(), 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
